// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply/divide unit owning HI/LO.
// Radix-2 shift-add multiply and restoring divide on magnitudes, followed by a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             multordiv,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic                 op_mul_q, op_mul_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 zero_div_q, zero_div_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_rem, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod_s;

  always_comb begin
    mag_a    = srca[WIDTH-1] ? (~srca + 1'b1) : srca;
    mag_b    = srcb[WIDTH-1] ? (~srcb + 1'b1) : srcb;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd_q};
    div_ge   = ~div_diff[WIDTH];
    prod_s   = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  end

  always_comb begin
    state_d    = state_q;
    op_mul_d   = op_mul_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    zero_div_d = zero_div_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          op_mul_d   = multordiv;
          neg_res_d  = srca[WIDTH-1] ^ srcb[WIDTH-1];
          neg_rem_d  = srca[WIDTH-1];
          zero_div_d = ~multordiv && (srcb == '0);
          opnd_d     = multordiv ? mag_a : mag_b;
          acc_d      = {{WIDTH{1'b0}}, (multordiv ? mag_b : mag_a)};
          cnt_d      = CW'(WIDTH);
          dbz_d      = 1'b0;
        end
      end
      RUN: begin
        if (op_mul_q) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_mul_q) begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end else begin
          // With a zero divisor the remainder path shifts the dividend through
          // unchanged, so hi already restores srca; only the quotient needs forcing.
          hi_d  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
          lo_d  = zero_div_q ? '1 :
                  (neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
          dbz_d = zero_div_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_mul_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_mul_q   <= op_mul_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      zero_div_q <= zero_div_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/div_by_zero queued at issue, checked at done.
module tb_muldiv_unit;

  logic        clk, reset, start, multordiv;
  logic [31:0] srca, srcb;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] prev_hi = 0, prev_lo = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .multordiv(multordiv),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start for exactly one edge; caller positions us at a negedge.
  task automatic issue(input bit op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t   e;
    longint p;
    int     sa, sb;
    if (op) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.dbz = 1'b0;
    end else if (b == 32'h0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi  = 32'h0;
      e.lo  = 32'h8000_0000;
      e.dbz = 1'b0;
    end else begin
      sa    = a;
      sb    = b;
      e.lo  = sa / sb;
      e.hi  = sa % sb;
      e.dbz = 1'b0;
    end
    if (push) sb_q.push_back(e);
    start     = 1'b1;
    multordiv = op;
    srca      = a;
    srcb      = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    srca  = $urandom;
    srcb  = $urandom;
  endtask

  task automatic wait_done(input string name, input int already);
    int   n = already;
    bit   seen = 0;
    bit   hold_ok = 1;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) n++;
      if (hi !== prev_hi || lo !== prev_lo) hold_ok = 0;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: done not seen within 40 cycles", name);
      return;
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard: done with no expected entry queued", name);
      return;
    end
    e = sb_q.pop_front();
    total++;
    if (n !== 33) begin bad++; $display("FAIL %s busy_cycles: got %0d want 33", name, n); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
    total++;
    if (!hold_ok) begin bad++; $display("FAIL %s hold: hi/lo changed while busy, want %h/%h", name, prev_hi, prev_lo); end
    total++;
    if (hi !== e.hi) begin bad++; $display("FAIL %s hi: got %h want %h", name, hi, e.hi); end
    total++;
    if (lo !== e.lo) begin bad++; $display("FAIL %s lo: got %h want %h", name, lo, e.lo); end
    total++;
    if (div_by_zero !== e.dbz) begin bad++; $display("FAIL %s dbz: got %b want %b", name, div_by_zero, e.dbz); end
    prev_hi = e.hi;
    prev_lo = e.lo;
  endtask

  task automatic run_op(input string name, input bit op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue(op, a, b, 1);
    wait_done(name, 0);
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL %s pulse: done got %b want 0", name, done); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (hi !== 32'h0)        begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== 32'h0)        begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    prev_hi = 0;
    prev_lo = 0;
  endtask

  task automatic test_mult();
    run_op("mul_7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD);
    run_op("mul_max", 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_op("mul_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000);
    run_op("mul_rand", 1'b1, $urandom, $urandom);
  endtask

  task automatic test_div();
    run_op("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_100_m7", 1'b0, 32'd100, 32'hFFFF_FFF9);
    run_op("div_small_big", 1'b0, 32'd3, 32'h8000_0000);
    run_op("div_rand", 1'b0, $urandom, $urandom_range(1, 1000));
  endtask

  task automatic test_div_zero();
    run_op("div_5_0", 1'b0, 32'd5, 32'd0);
    total++;
    if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_held: got %b want 1", div_by_zero); end
    @(negedge clk);
    issue(1'b1, 32'd2, 32'd3, 1);
    total++;
    if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear_at_start: got %b want 0", div_by_zero); end
    wait_done("mul_2_3", 0);
    run_op("div_neg_0", 1'b0, 32'hFFFF_FF00, 32'd0);
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    issue(1'b1, 32'd100, 32'd200, 1);
    for (int i = 0; i < 5; i++) @(negedge clk);
    start     = 1'b1;
    multordiv = 1'b0;
    srca      = 32'd1000;
    srcb      = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore_mid", 5);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL ignore_no_second_op: busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    issue(1'b0, 32'd77, 32'd5, 1);
    wait_done("b2b_first", 0);
    issue(1'b1, 32'hFFFF_FFF6, 32'd9, 1);
    wait_done("b2b_second", 0);
    issue(1'b0, 32'hFFFF_FF9C, 32'd7, 1);
    wait_done("b2b_third", 0);
  endtask

  task automatic test_abort();
    bit spurious = 0;
    @(negedge clk);
    issue(1'b0, 32'd1000, 32'd7, 0);
    repeat (9) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (hi !== 32'h0)   begin bad++; $display("FAIL abort_hi: got %h want 0", hi); end
    total++; if (lo !== 32'h0)   begin bad++; $display("FAIL abort_lo: got %h want 0", lo); end
    reset   = 1'b1;
    prev_hi = 0;
    prev_lo = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) spurious = 1;
    end
    total++;
    if (spurious) begin bad++; $display("FAIL abort_no_done: got done=1 want none"); end
    run_op("after_abort", 1'b1, 32'hFFFF_FFFC, 32'd5);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    multordiv = 1'b0;
    srca      = 32'h0;
    srcb      = 32'h0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
